// File: rtl/tensor_stream_loader.sv
// tensor_stream_loader: reads a tensor header from on-chip memory, decodes the
// tensor size, then streams the tensor words out on a valid/ready interface.
// A 2-entry skid FIFO absorbs the 1-cycle memory read latency so downstream
// backpressure never drops a word.
// Optional build macro: LOADER_STALL_CNT_EN enables the stall_cycles counter;
// without it stall_cycles is tied to zero.
module tensor_stream_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int BANDWIDTH  = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    output logic                            mem_read,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    input  logic [DATA_WIDTH*BANDWIDTH-1:0] mem_readdata,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH*BANDWIDTH-1:0] out_data,
    output logic                            out_last,
    output logic [3:0]                      hdr_op,
    output logic [6:0]                      hdr_rows,
    output logic [6:0]                      hdr_cols,
    output logic [13:0]                     hdr_aux,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [15:0]                     stall_cycles
);

    localparam int W     = DATA_WIDTH * BANDWIDTH;
    localparam int SHIFT = $clog2(BANDWIDTH);
    // rows*cols is a 14-bit product, so the word count always fits in 14 bits.
    localparam int CNT_W = 14;
    localparam int EXT_W = ((ADDR_WIDTH > CNT_W) ? ADDR_WIDTH : CNT_W) + 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HDR_REQ  = 3'd1;
    localparam logic [2:0] S_HDR_WAIT = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] rp_q;
    logic [CNT_W-1:0]      issued_q;
    logic [CNT_W-1:0]      n_q;
    logic                  error_q;
    logic [3:0]            hdr_op_q;
    logic [6:0]            hdr_rows_q;
    logic [6:0]            hdr_cols_q;
    logic [13:0]           hdr_aux_q;

    logic                  inflight_q;
    logic                  inflight_last_q;

    logic [W-1:0]          fifo_data_q [2];
    logic                  fifo_last_q [2];
    logic                  fifo_rd_q;
    logic                  fifo_wr_q;
    logic [1:0]            fifo_cnt_q;

    // Header decode, evaluated while the header word is on mem_readdata.
    logic [31:0]           hdr_word;
    logic [CNT_W-1:0]      prod;
    logic [CNT_W:0]        prod_rnd;
    logic [CNT_W-1:0]      n_calc;
    logic [EXT_W-1:0]      last_addr;
    logic                  hdr_bad;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occupancy;

    assign hdr_word  = mem_readdata[31:0];
    assign prod      = CNT_W'(hdr_word[27:21]) * CNT_W'(hdr_word[20:14]);
    assign prod_rnd  = {1'b0, prod} + (CNT_W + 1)'(BANDWIDTH - 1);
    assign n_calc    = CNT_W'(prod_rnd >> SHIFT);
    assign last_addr = EXT_W'(base_q) + EXT_W'(n_calc);
    assign hdr_bad   = (hdr_word[27:21] == 7'd0) || (hdr_word[20:14] == 7'd0) ||
                       (last_addr > EXT_W'((1 << ADDR_WIDTH) - 1));

    // Handshake and read-issue decisions. Occupancy counts words already held
    // plus the one still in flight, net of the word leaving this cycle, so the
    // FIFO can never be asked to hold a third word.
    assign out_valid = (fifo_cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q;
    assign occupancy = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == S_STREAM) && (issued_q < n_q) && (occupancy < 3'd2);

    assign mem_read    = (state_q == S_HDR_REQ) | issue;
    assign mem_address = (state_q == S_HDR_REQ) ? base_q :
                         issue                  ? rp_q   : '0;

    // Gating with out_valid keeps the outputs at zero while the unreset FIFO
    // storage holds stale or undefined contents.
    assign out_data = out_valid ? fifo_data_q[fifo_rd_q] : '0;
    assign out_last = out_valid & fifo_last_q[fifo_rd_q];

    assign busy     = (state_q == S_HDR_REQ) || (state_q == S_HDR_WAIT) || (state_q == S_STREAM);
    assign done     = (state_q == S_DONE);
    assign error    = error_q;
    assign hdr_op   = hdr_op_q;
    assign hdr_rows = hdr_rows_q;
    assign hdr_cols = hdr_cols_q;
    assign hdr_aux  = hdr_aux_q;

    // Next-state logic for the load sequencer.
    always_comb begin
        // NOTE: state_d gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_HDR_REQ;
            S_HDR_REQ:  state_d = S_HDR_WAIT;
            S_HDR_WAIT: state_d = hdr_bad ? S_DONE : S_STREAM;
            S_STREAM:   if (pop && out_last) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Sequencer state, header registers, read pointer and issue count.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this clock edge.
        if (reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            rp_q       <= '0;
            issued_q   <= '0;
            n_q        <= '0;
            error_q    <= 1'b0;
            hdr_op_q   <= '0;
            hdr_rows_q <= '0;
            hdr_cols_q <= '0;
            hdr_aux_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                base_q  <= base_addr;
                error_q <= 1'b0;
            end
            if (state_q == S_HDR_WAIT) begin
                hdr_op_q   <= hdr_word[31:28];
                hdr_rows_q <= hdr_word[27:21];
                hdr_cols_q <= hdr_word[20:14];
                hdr_aux_q  <= hdr_word[13:0];
                n_q        <= n_calc;
                rp_q       <= base_q + ADDR_WIDTH'(1);
                issued_q   <= '0;
                if (hdr_bad) error_q <= 1'b1;
            end
            if (issue) begin
                rp_q     <= rp_q + ADDR_WIDTH'(1);
                issued_q <= issued_q + CNT_W'(1);
            end
        end
    end

    // In-flight read tracking; the tag marks the read of the final word.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && ((issued_q + CNT_W'(1)) == n_q);
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) fifo_wr_q <= ~fifo_wr_q;
            if (pop)  fifo_rd_q <= ~fifo_rd_q;
            fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
        end
    end

    // FIFO storage captures the returning memory word and its last tag.
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset; it is only observed through
        // out_valid, which the reset-cleared pointers and count control.
        if (push) begin
            fifo_data_q[fifo_wr_q] <= mem_readdata;
            fifo_last_q[fifo_wr_q] <= inflight_last_q;
        end
    end

`ifdef LOADER_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of streaming cycles where the consumer holds off a word.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            stall_q <= '0;
        end else if (state_q == S_STREAM && out_valid && !out_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_tensor_stream_loader.sv
// Self-checking bench for tensor_stream_loader: a table of load scenarios,
// hand-written reset/idle sequences, and randomized headers checked against a
// behavioural model of the header rules and a memory array.
module tb_tensor_stream_loader;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   base_addr;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [255:0] mem_readdata = '0;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic         out_last;
    logic [3:0]   hdr_op;
    logic [6:0]   hdr_rows;
    logic [6:0]   hdr_cols;
    logic [13:0]  hdr_aux;
    logic         busy;
    logic         done;
    logic         error;
    logic [15:0]  stall_cycles;

    tensor_stream_loader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .hdr_op       (hdr_op),
        .hdr_rows     (hdr_rows),
        .hdr_cols     (hdr_cols),
        .hdr_aux      (hdr_aux),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .stall_cycles (stall_cycles)
    );

    always #5 clock = ~clock;

    // Memory: 1-cycle read latency, zero data when no read was issued.
    logic [255:0] mem [64];
    int           reads_cnt = 0;

    always @(posedge clock) begin
        mem_readdata <= mem_read ? mem[mem_address] : '0;
        if (mem_read) reads_cnt <= reads_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  base;
        logic [3:0]  op;
        logic [6:0]  rows;
        logic [6:0]  cols;
        logic [13:0] aux;
        logic [3:0]  rpat;      // out_ready for cycle idx is rpat[idx % 4]
        int          intr_idx;  // cycle to pulse a stray start, -1 for none
        bit          exp_err;
        int          exp_n;
    } vec_t;

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    // Reference rules: N = ceil(rows*cols/8); fault on a zero dimension or
    // when the last tensor word would lie beyond address 63.
    function automatic void model(input vec_t v, output bit err, output int n);
        int prod;
        prod = int'(v.rows) * int'(v.cols);
        n    = (prod + 7) / 8;
        err  = (v.rows == 0) || (v.cols == 0) || (int'(v.base) + n > 63);
    endfunction

    task automatic set_header(input logic [5:0] base, input logic [31:0] hdr);
        logic [255:0] w;
        w = rand_word();
        w[31:0] = hdr;
        mem[base] = w;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_read"}, 256'(mem_read), 256'(0));
        check({tag, "_mem_address"}, 256'(mem_address), 256'(0));
        check({tag, "_out_valid"}, 256'(out_valid), 256'(0));
        check({tag, "_out_data"}, out_data, 256'(0));
        check({tag, "_out_last"}, 256'(out_last), 256'(0));
        check({tag, "_hdr"}, 256'({hdr_op, hdr_rows, hdr_cols, hdr_aux}), 256'(0));
        check({tag, "_busy"}, 256'(busy), 256'(0));
        check({tag, "_done"}, 256'(done), 256'(0));
        check({tag, "_error"}, 256'(error), 256'(0));
        check({tag, "_stall"}, 256'(stall_cycles), 256'(0));
    endtask

    // Runs one load end to end and checks it against the expected outcome.
    task automatic run_load(input string tag, input vec_t v);
        logic [255:0] got_data [$];
        bit           got_last [$];
        int           reads0, first_valid, last_hs, done_idx, stalls, exp_stall;
        bit           prev_stall;
        logic [255:0] prev_data;
        logic         prev_last;

        set_header(v.base, {v.op, v.rows, v.cols, v.aux});
        for (int i = 1; i <= v.exp_n && int'(v.base) + i < 64; i++) mem[int'(v.base) + i] = rand_word();

        first_valid = -1;
        last_hs     = -1;
        done_idx    = -1;
        stalls      = 0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        prev_last   = 1'b0;

        @(negedge clock);
        start     = 1'b1;
        base_addr = v.base;
        out_ready = 1'b0;
        reads0    = reads_cnt;

        // idx counts cycles after the edge that samples start.
        for (int idx = 0; idx < 800; idx++) begin
            @(negedge clock);
            start     = (idx == v.intr_idx);
            base_addr = start ? v.base + 6'd5 : v.base;
            out_ready = v.rpat[idx % 4];
            #1;
            if (idx == 0) begin
                check({tag, "_busy_on"}, 256'(busy), 256'(1));
                check({tag, "_err_clear"}, 256'(error), 256'(0));
            end
            if (prev_stall) begin
                check({tag, "_hold_valid"}, 256'(out_valid), 256'(1));
                check({tag, "_hold_data"}, out_data, prev_data);
                check({tag, "_hold_last"}, 256'(out_last), 256'(prev_last));
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = idx;
                if (out_ready) begin
                    got_data.push_back(out_data);
                    got_last.push_back(out_last);
                    last_hs = idx;
                end else begin
                    stalls++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) begin
                done_idx = idx;
                check({tag, "_busy_at_done"}, 256'(busy), 256'(0));
                check({tag, "_error"}, 256'(error), 256'(v.exp_err));
                check({tag, "_hdr_op"}, 256'(hdr_op), 256'(v.op));
                check({tag, "_hdr_rows"}, 256'(hdr_rows), 256'(v.rows));
                check({tag, "_hdr_cols"}, 256'(hdr_cols), 256'(v.cols));
                check({tag, "_hdr_aux"}, 256'(hdr_aux), 256'(v.aux));
`ifdef LOADER_STALL_CNT_EN
                exp_stall = stalls;
`else
                exp_stall = 0;
`endif
                check({tag, "_stall_cycles"}, 256'(stall_cycles), 256'(exp_stall));
                break;
            end
        end
        start = 1'b0;

        if (done_idx < 0) begin
            check({tag, "_done_timeout"}, 256'(0), 256'(1));
        end else begin
            check({tag, "_word_count"}, 256'(got_data.size()), 256'(v.exp_n));
            for (int i = 0; i < got_data.size() && i < v.exp_n; i++) begin
                check($sformatf("%s_word%0d", tag, i), got_data[i], mem[int'(v.base) + 1 + i]);
                check($sformatf("%s_last%0d", tag, i), 256'(got_last[i]), 256'(i == v.exp_n - 1));
            end
            if (v.exp_err) begin
                check({tag, "_no_valid"}, 256'(first_valid), 256'(-1));
                check({tag, "_reads"}, 256'(reads_cnt - reads0), 256'(1));
            end else begin
                check({tag, "_latency"}, 256'(first_valid), 256'(4));
                check({tag, "_done_after_last"}, 256'(done_idx), 256'(last_hs + 1));
                check({tag, "_reads"}, 256'(reads_cnt - reads0), 256'(v.exp_n + 1));
            end
            @(negedge clock);
            #1;
            check({tag, "_done_pulse"}, 256'(done), 256'(0));
            check({tag, "_error_sticky"}, 256'(error), 256'(v.exp_err));
            check({tag, "_idle_busy"}, 256'(busy), 256'(0));
        end
    endtask

    vec_t tbl [10];

    initial begin
        // base, op, rows, cols, aux, ready pattern, stray start, err, N
        tbl[0] = '{6'd0,  4'd1,  7'd16, 7'd12, 14'h080C, 4'b1111, -1, 1'b0, 24}; // nominal
        tbl[1] = '{6'd0,  4'd1,  7'd16, 7'd12, 14'h080C, 4'b1001, -1, 1'b0, 24}; // ready 1,0,0,1
        tbl[2] = '{6'd10, 4'd2,  7'd5,  7'd0,  14'h1234, 4'b1111, -1, 1'b1, 0};  // cols=0
        tbl[3] = '{6'd40, 4'd1,  7'd16, 7'd12, 14'h080C, 4'b1111, -1, 1'b1, 0};  // 40+24 > 63
        tbl[4] = '{6'd3,  4'd1,  7'd16, 7'd12, 14'h080C, 4'b1111, 8,  1'b0, 24}; // start while busy
        tbl[5] = '{6'd20, 4'd15, 7'd0,  7'd9,  14'h3FFF, 4'b1111, -1, 1'b1, 0};  // rows=0
        tbl[6] = '{6'd39, 4'd1,  7'd16, 7'd12, 14'h080C, 4'b1101, -1, 1'b0, 24}; // ends at 63
        tbl[7] = '{6'd62, 4'd7,  7'd1,  7'd1,  14'h0001, 4'b0110, -1, 1'b0, 1};  // single word
        tbl[8] = '{6'd50, 4'd3,  7'd3,  7'd5,  14'h2AAA, 4'b1111, -1, 1'b0, 2};  // partial word
        tbl[9] = '{6'd63, 4'd4,  7'd1,  7'd1,  14'h0000, 4'b1111, -1, 1'b1, 0};  // 63+1 > 63

        for (int a = 0; a < 64; a++) mem[a] = rand_word();

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        for (int t = 0; t < 10; t++) run_load($sformatf("tbl%0d", t), tbl[t]);

        // Reset mid-stream after five words, then a clean reload.
        begin
            int hs;
            hs = 0;
            set_header(6'd0, 32'h1203080C);
            @(negedge clock);
            start     = 1'b1;
            base_addr = 6'd0;
            out_ready = 1'b1;
            @(negedge clock);
            start = 1'b0;
            for (int c = 0; c < 100 && hs < 5; c++) begin
                @(negedge clock);
                #1;
                if (out_valid && out_ready) hs++;
            end
            check("midrst_words_before", 256'(hs), 256'(5));
            reset = 1'b1;
            @(negedge clock);
            #1;
            check_all_zero("midrst");
            reset = 1'b0;
            @(negedge clock);
            #1;
            check("midrst_discard_valid", 256'(out_valid), 256'(0));
            check("midrst_no_done", 256'(done), 256'(0));
            run_load("after_rst", tbl[0]);
        end

        // Randomized headers checked against the reference rules.
        for (int r = 0; r < 12; r++) begin
            vec_t v;
            bit   e;
            int   n;
            v.base     = 6'($urandom_range(0, 24));
            v.op       = 4'($urandom());
            v.rows     = 7'($urandom_range(0, 20));
            v.cols     = 7'($urandom_range(0, 20));
            v.aux      = 14'($urandom());
            v.rpat     = 4'($urandom_range(1, 15));
            v.intr_idx = -1;
            model(v, e, n);
            v.exp_err  = e;
            v.exp_n    = e ? 0 : n;
            run_load($sformatf("rand%0d", r), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
